// File: rtl/muldiv_unit_pkg.sv
// Shared configuration for the execute stage.
// Holds the default datapath width, the RV32M multiply/divide opcode
// encoding (md_op_e) and small predicates that classify an opcode.
package pkg_config;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_e;

    // All divide/remainder encodings have bit 2 set.
    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic md_a_signed(input md_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic md_b_signed(input md_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   valid_i, ready_o  request handshake (md_op_i, a_i, b_i)
//   kill_i            abandon in-flight or completed operation
//   valid_o, ready_i  result handshake (c_o, registered)
// Multiply is radix-2 shift-add on a 2*DATA_WIDTH register whose low half
// starts as the multiplier; divide is restoring division where the low half
// starts as the dividend and fills with quotient bits, the high half being
// the partial remainder. Both share prod_q, opr_q and the counter.
module muldiv_unit #(
    parameter int DATA_WIDTH = pkg_config::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            md_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  kill_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] c_o
);
    import pkg_config::*;

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_e;

    md_state_e       state, state_nxt;
    logic [CW-1:0]   cnt;
    md_op_e          op_q;
    logic            neg_q;      // result (product / quotient) needs negation
    logic            a_neg_q;    // dividend was negative: remainder sign
    logic [W-1:0]    opr_q;      // multiplicand or divisor magnitude
    logic [2*W-1:0]  prod_q;

    // ---------------- request decode ----------------
    md_op_e         op;
    logic           a_sgn, b_sgn, div0, ovf, special, accept, last;
    logic [W-1:0]   a_mag, b_mag, spec_res;

    assign op      = md_op_e'(md_op_i);
    assign a_sgn   = md_a_signed(op) && a_i[W-1];
    assign b_sgn   = md_b_signed(op) && b_i[W-1];
    assign a_mag   = a_sgn ? -a_i : a_i;
    assign b_mag   = b_sgn ? -b_i : b_i;
    assign div0    = md_is_div(op) && (b_i == '0);
    assign ovf     = ((op == DIV) || (op == REM)) && (a_i == MIN_VAL) && (b_i == '1);
    assign special = div0 || ovf;
    assign accept  = valid_i && ready_o;
    assign last    = (cnt == CW'(W-1));

    always_comb begin
        spec_res = '0;
        if (div0)
            spec_res = ((op == REM) || (op == REMU)) ? a_i : '1;
        else if (ovf)
            spec_res = (op == DIV) ? MIN_VAL : '0;
    end

    // ---------------- one iteration step ----------------
    logic [W:0]     mul_sum, div_sh, div_diff;
    logic [2*W-1:0] prod_nxt, prod_fix;
    logic [W-1:0]   quo, rem, res;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opr_q} : '0);
        div_sh   = {prod_q[2*W-1:W], prod_q[W-1]};
        div_diff = div_sh - {1'b0, opr_q};
        if (md_is_div(op_q))
            // Borrow out means the divisor did not fit: keep the shifted remainder.
            prod_nxt = div_diff[W] ? {div_sh[W-1:0],   prod_q[W-2:0], 1'b0}
                                   : {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
        else
            prod_nxt = {mul_sum, prod_q[W-1:1]};
    end

    // Sign correction and result selection from the final step's value.
    always_comb begin
        prod_fix = neg_q ? -prod_nxt : prod_nxt;
        quo      = prod_nxt[W-1:0];
        rem      = prod_nxt[2*W-1:W];
        case (op_q)
            MUL:                  res = prod_fix[W-1:0];
            MULH, MULHSU, MULHU:  res = prod_fix[2*W-1:W];
            DIV, DIVU:            res = neg_q ? -quo : quo;
            default:              res = a_neg_q ? -rem : rem;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: if (last)   state_nxt = DONE;
            DONE: if (ready_i) state_nxt = accept ? (special ? DONE : CALC) : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill_i) state_nxt = IDLE;
    end

    always_comb begin
        ready_o = (state == IDLE) || ((state == DONE) && ready_i);
        valid_o = (state == DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            op_q    <= MUL;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            opr_q   <= '0;
            prod_q  <= '0;
            c_o     <= '0;
        end else if (!kill_i) begin
            if (accept) begin
                cnt     <= '0;
                op_q    <= op;
                neg_q   <= a_sgn ^ b_sgn;
                a_neg_q <= a_sgn;
                opr_q   <= md_is_div(op) ? b_mag : a_mag;
                prod_q  <= {{W{1'b0}}, (md_is_div(op) ? a_mag : b_mag)};
                if (special) c_o <= spec_res;
            end else if (state == CALC) begin
                cnt    <= cnt + 1'b1;
                prod_q <= prod_nxt;
                if (last) c_o <= res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import pkg_config::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  md_op_i = 3'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] c_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .md_op_i(md_op_i), .a_i(a_i), .b_i(b_i), .kill_i(kill_i),
        .valid_o(valid_o), .ready_i(ready_i), .c_o(c_o)
    );

    // Behavioural reference using wide native arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        logic [63:0] p;
        int ia, ib;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ia  = $signed(a);
        ib  = $signed(b);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb2); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one op from IDLE, waits for the result, checks value and the
    // number of edges between the accept edge and valid_o, then consumes it.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic [31:0] e;
        valid_i = 1'b1; md_op_i = op; a_i = a; b_i = b;
        sb.push_back(exp);
        @(negedge clk);
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        total++;
        if (!valid_o) begin
            bad++;
            $display("FAIL %s timeout: valid_o never rose", name);
        end else begin
            if (c_o !== e) begin
                bad++;
                $display("FAIL %s result: got %h want %h", name, c_o, e);
            end
            total++;
            if (lat != exp_lat) begin
                bad++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
            end
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (valid_o !== 1'b0 || c_o !== 32'h0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset: valid_o=%b c_o=%h ready_o=%b want 0/0/1", valid_o, c_o, ready_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        do_op("mul",    MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
        do_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        do_op("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
        do_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    endtask

    task automatic test_div();
        do_op("div",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        do_op("rem",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        do_op("divu", DIVU, 32'd100,       32'd7, 32'd14,        32);
        do_op("remu", REMU, 32'd100,       32'd7, 32'd2,         32);
    endtask

    // Special cases reach DONE on the accept edge itself.
    task automatic test_special();
        do_op("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        do_op("rem_by0",  REM,  32'd5, 32'd0, 32'd5,         0);
        do_op("div_ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op("rem_ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (i == 5) a = 32'hFFFF_FF80;      // negative small dividend
            do_op("random", op, a, b, model(op, a, b), 32);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] e;
        valid_i = 1'b1; md_op_i = MUL; a_i = 32'd3; b_i = 32'd5;
        sb.push_back(model(MUL, 32'd3, 32'd5));
        @(negedge clk);
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        total++;
        if (c_o !== e || valid_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_first: c_o=%h valid_o=%b want %h/1", c_o, valid_o, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (c_o !== e || valid_o !== 1'b1 || ready_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: c_o=%h valid_o=%b ready_o=%b want %h/1/0", c_o, valid_o, ready_o, e);
            end
        end
        // Release and present the next request in the same cycle.
        ready_i = 1'b1;
        valid_i = 1'b1; md_op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
        sb.push_back(32'd14);
        #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready: ready_o=%b want 1", ready_o);
        end
        @(negedge clk);
        valid_i = 1'b0; ready_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        total++;
        if (c_o !== e || lat != 32) begin
            bad++;
            $display("FAIL bp_next: c_o=%h lat=%0d want %h lat 32", c_o, lat, e);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic test_kill_reset();
        int seen;
        valid_i = 1'b1; md_op_i = MUL; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (10) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL kill: ready_o=%b valid_o=%b want 1/0", ready_o, valid_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL kill_quiet: valid_o high %0d cycles want 0", seen);
        end
        // Reset while a result waits in DONE.
        valid_i = 1'b1; md_op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (32) @(negedge clk);
        total++;
        if (valid_o !== 1'b1 || c_o !== 32'd14) begin
            bad++;
            $display("FAIL pre_rst: valid_o=%b c_o=%h want 1/0000000e", valid_o, c_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        total++;
        if (valid_o !== 1'b0 || c_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_done: valid_o=%b c_o=%h want 0/0", valid_o, c_o);
        end
        do_op("mul_after_rst", MUL, 32'd3, 32'd4, 32'd12, 32);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_kill_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
